// File: rtl/pe_output_collector.sv
// Collects 8-lane PE result columns into an 8x8 buffer and drains them one word
// at a time over a valid/ready port, oldest column first, lanes 0..7 in order.
module pe_output_collector #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int SIZE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic [DATA_W-1:0] wr_data_2,
  input  logic [DATA_W-1:0] wr_data_3,
  input  logic [DATA_W-1:0] wr_data_4,
  input  logic [DATA_W-1:0] wr_data_5,
  input  logic [DATA_W-1:0] wr_data_6,
  input  logic [DATA_W-1:0] wr_data_7,
  input  logic [DATA_W-1:0] wr_data_8,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_addr,
  output logic [3:0]        count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [2:0] LAST_LANE  = 3'(LANES - 1);
  localparam logic [3:0] FULL_COUNT = 4'(SIZE);

  logic [DATA_W-1:0] mem_q [LANES][SIZE];
  logic [DATA_W-1:0] wrLane [LANES];

  logic [2:0] wrPtr_q, wrPtr_d;
  logic [2:0] rdPtr_q, rdPtr_d;
  logic [2:0] lanePtr_q, lanePtr_d;
  logic [3:0] count_q, count_d;
  logic       overflow_q, overflow_d;

  logic isFull;
  logic wrAccept;
  logic xfer;
  logic retire;

  assign wrLane[0] = wr_data_1;
  assign wrLane[1] = wr_data_2;
  assign wrLane[2] = wr_data_3;
  assign wrLane[3] = wr_data_4;
  assign wrLane[4] = wr_data_5;
  assign wrLane[5] = wr_data_6;
  assign wrLane[6] = wr_data_7;
  assign wrLane[7] = wr_data_8;

  // Fullness is judged on the registered count, so a retiring column never frees a slot the same cycle.
  assign isFull   = (count_q == FULL_COUNT);
  assign wrAccept = wr_en && !clr && !isFull;
  assign xfer     = out_valid && out_ready;
  assign retire   = xfer && (lanePtr_q == LAST_LANE);

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      for (int k = 0; k < LANES; k++) begin
        mem_q[k][wrPtr_q] <= wrLane[k];
      end
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    lanePtr_d  = lanePtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      lanePtr_d  = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + 3'd1;
      end
      if (wr_en && isFull) begin
        overflow_d = 1'b1;
      end
      if (xfer) begin
        lanePtr_d = lanePtr_q + 3'd1;
      end
      if (retire) begin
        rdPtr_d = rdPtr_q + 3'd1;
      end
      case ({wrAccept, retire})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      lanePtr_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      lanePtr_q  <= lanePtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs are forced to zero when idle so reset shows clean values despite unreset storage.
  assign out_valid = (count_q != 4'd0);
  assign out_data  = out_valid ? mem_q[lanePtr_q][rdPtr_q] : '0;
  assign out_addr  = out_valid ? {lanePtr_q, rdPtr_q} : 6'd0;
  assign count     = count_q;
  assign full      = isFull;
  assign empty     = (count_q == 4'd0);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pe_output_collector.sv
// Scoreboard bench for pe_output_collector: directed column writes push expected
// words into a queue, and a monitor pops and compares every drained word.
module tb_pe_output_collector;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wd [8];
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_addr;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  expT sb[$];
  int  checkCount = 0;
  int  errorCount = 0;
  int  wrSlot = 0;

  always #5 clk = ~clk;

  pe_output_collector #(.DATA_W(16), .LANES(8), .SIZE(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en),
    .wr_data_1(wd[0]), .wr_data_2(wd[1]), .wr_data_3(wd[2]), .wr_data_4(wd[3]),
    .wr_data_5(wd[4]), .wr_data_6(wd[5]), .wr_data_7(wd[6]), .wr_data_8(wd[7]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  // Monitor: every word handed over is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      expT e;
      checkCount++;
      if (sb.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL unexpected_word: got addr %0d data %h, expected no word", out_addr, out_data);
      end else begin
        e = sb.pop_front();
        if (out_addr !== e.addr || out_data !== e.data) begin
          errorCount++;
          $display("[TB] FAIL drain_word: got addr %0d data %h, expected addr %0d data %h",
                   out_addr, out_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setColumn(input logic [15:0] base);
    for (int k = 0; k < 8; k++) wd[k] = base + 16'(k);
  endtask

  task automatic pushColumn(input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      expT e;
      e.addr = {3'(k), 3'(wrSlot)};
      e.data = base + 16'(k);
      sb.push_back(e);
    end
    wrSlot = (wrSlot + 1) % 8;
  endtask

  // One-cycle column write; only columns expected to be accepted enter the scoreboard.
  task automatic applyStimulus(input logic [15:0] base, input bit accept);
    setColumn(base);
    wr_en = 1'b1;
    if (accept) pushColumn(base);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic waitEmpty(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (empty && sb.size() == 0) done = 1;
      else tick();
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    setColumn(16'h0000);
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_data", {16'd0, out_data}, 0);
    checkOutput("rst_addr", {26'd0, out_addr}, 0);
    checkOutput("rst_count", {28'd0, count}, 0);
    checkOutput("rst_empty", {31'd0, empty}, 1);
    checkOutput("rst_full", {31'd0, full}, 0);
    checkOutput("rst_overflow", {31'd0, overflow}, 0);
    rst = 1'b0;
    tick();

    // Single column, streaming drain.
    out_ready = 1'b1;
    applyStimulus(16'h0100, 1);
    checkOutput("latency_valid", {31'd0, out_valid}, 1);
    checkOutput("latency_addr", {26'd0, out_addr}, 0);
    checkOutput("latency_data", {16'd0, out_data}, 32'h0100);
    waitEmpty("single_drain", 40);
    checkOutput("single_count", {28'd0, count}, 0);

    // Fill to full with the port stalled, then one dropped write.
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) applyStimulus(16'h1000 + 16'(c * 16), 1);
    checkOutput("fill_full", {31'd0, full}, 1);
    checkOutput("fill_count", {28'd0, count}, 8);
    checkOutput("stall_data", {16'd0, out_data}, 32'h1000);
    checkOutput("stall_addr", {26'd0, out_addr}, 1);
    applyStimulus(16'hDEAD, 0);
    checkOutput("ovf_set", {31'd0, overflow}, 1);
    checkOutput("ovf_count", {28'd0, count}, 8);
    checkOutput("stall_hold_data", {16'd0, out_data}, 32'h1000);
    checkOutput("stall_hold_addr", {26'd0, out_addr}, 1);
    out_ready = 1'b1;
    waitEmpty("full_drain", 100);
    checkOutput("ovf_sticky", {31'd0, overflow}, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    wrSlot = 0;
    checkOutput("clr_overflow", {31'd0, overflow}, 0);

    // Full buffer with wr_en held while the first column drains.
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) applyStimulus(16'h2000 + 16'(c * 16), 1);
    setColumn(16'h3000);
    wr_en = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    checkOutput("retire_drop_count", {28'd0, count}, 7);
    checkOutput("retire_drop_ovf", {31'd0, overflow}, 1);
    pushColumn(16'h3000);
    tick();
    wr_en = 1'b0;
    checkOutput("refill_count", {28'd0, count}, 8);
    waitEmpty("refill_drain", 120);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wrSlot = 0;

    // Stream 20 columns with out_ready toggling every cycle.
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(16'h8000 + 16'(c * 16), 1);
      out_ready = !out_ready;
      repeat (15) begin
        tick();
        out_ready = !out_ready;
      end
    end
    out_ready = 1'b1;
    waitEmpty("stream_drain", 100);
    checkOutput("stream_overflow", {31'd0, overflow}, 0);

    // Asynchronous reset mid-drain.
    applyStimulus(16'h4000, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_count", {28'd0, count}, 0);
    sb.delete();
    wrSlot = 0;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    applyStimulus(16'h5000, 1);
    checkOutput("postrst_addr", {26'd0, out_addr}, 0);
    checkOutput("postrst_data", {16'd0, out_data}, 32'h5000);
    out_ready = 1'b1;
    waitEmpty("postrst_drain", 40);

    // clr beats a simultaneous write and transfer.
    out_ready = 1'b0;
    applyStimulus(16'h6000, 1);
    clr = 1'b1;
    setColumn(16'h7000);
    wr_en = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    sb.delete();
    wrSlot = 0;
    checkOutput("clr_count", {28'd0, count}, 0);
    checkOutput("clr_ovf", {31'd0, overflow}, 0);
    checkOutput("clr_valid", {31'd0, out_valid}, 0);
    checkOutput("clr_empty", {31'd0, empty}, 1);
    tick();
    checkOutput("clr_nothing_stored", {31'd0, out_valid}, 0);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pe_output_collector.md
PE_OUTPUT_COLLECTOR -- requirements
Module: pe_output_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each lane word.
REQ-002 SHALL have parameter LANES, default 8, number of parallel lanes; fixed at 8 for this revision.
REQ-003 SHALL have parameter SIZE, default 8, column depth per lane; fixed at 8 for this revision.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous flush of pointers, count and overflow.
REQ-007 SHALL have port wr_en  input  1  request to store one column (all 8 lanes).
REQ-008 SHALL have ports wr_data_1..wr_data_8  input  DATA_W each  lane words of the column.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unread word.
REQ-011 SHALL have port out_data  output  DATA_W  current word to drain.
REQ-012 SHALL have port out_addr  output  6  layout index of current word = 8*lane + slot.
REQ-013 SHALL have port count  output  4  occupied columns, 0..8.
REQ-014 SHALL have ports full, empty  output  1 each  count==8, count==0.
REQ-015 SHALL have port overflow  output  1  sticky flag, a write was dropped.

Function
REQ-016 Storage SHALL be an 8x8 array of DATA_W words indexed [lane][slot]; storage SHALL NOT be reset.
REQ-017 State SHALL be wr_ptr[2:0], rd_ptr[2:0] (slot), lane_ptr[2:0], count[3:0], overflow.
REQ-018 Write accepted when wr_en=1 and count<8 (registered value, that cycle); stores wr_data_k into [k-1][wr_ptr] for k=1..8.
REQ-019 On accepted write wr_ptr SHALL advance by 1, wrapping 7->0.
REQ-020 wr_en=1 with count==8 SHALL drop the column, leave wr_ptr unchanged and set overflow; this holds even if a column retires in the same cycle.
REQ-021 out_valid SHALL equal (count!=0), from registered state only.
REQ-022 out_data SHALL equal storage[lane_ptr][rd_ptr] when out_valid=1, else 0; out_addr SHALL equal {lane_ptr, rd_ptr} when out_valid=1, else 0.
REQ-023 Transfer occurs when out_valid=1 and out_ready=1; lane_ptr SHALL then advance by 1.
REQ-024 Transfer with lane_ptr==7 SHALL set lane_ptr to 0, advance rd_ptr by 1 (wrap 7->0) and retire the column.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_addr SHALL hold stable.
REQ-026 count SHALL increment on accepted write only, decrement on retire only, and remain unchanged when both occur in one cycle.
REQ-027 Write latency: a column written into an empty buffer SHALL show out_valid=1 on the cycle after the write edge, with lane 0 first.
REQ-028 Drain order SHALL be oldest column first, lanes 0..7 within a column; sustained out_ready=1 gives one word per cycle.
REQ-029 clr=1 SHALL on that edge zero wr_ptr, rd_ptr, lane_ptr, count, overflow, and SHALL take priority over a simultaneous write or transfer.
REQ-030 A write to slot rd_ptr while that column is partially drained SHALL NOT be possible (blocked by count==8).

Reset
REQ-031 rst=1 SHALL immediately force wr_ptr=0, rd_ptr=0, lane_ptr=0, count=0, overflow=0.
REQ-032 During and after reset, outputs SHALL be out_valid=0, out_data=0, out_addr=0, count=0, empty=1, full=0, overflow=0.
REQ-033 rst asserted mid-drain SHALL discard all stored columns; first write after release SHALL go to slot 0.

Verification
REQ-034 Write one column 0x0100..0x0107 (lanes 1..8), out_ready=1 -> next cycle out_valid=1, 8 words 0x0100..0x0107 with out_addr 0,8,16..56, then empty=1.
REQ-035 Write 8 columns with out_ready=0 -> full=1, count=8; 9th wr_en -> overflow=1, count stays 8, stored data unchanged.
REQ-036 Full buffer, out_ready=1, wr_en=1 held -> write at lane_ptr=7 transfer cycle dropped (overflow=1); next cycle write accepted, count returns to 8.
REQ-037 Stream 20 columns, out_ready toggling 1/0 -> all 160 words out in order, rd_ptr and wr_ptr wrap correctly, no overflow.
REQ-038 Assert rst after 3 words of column 0 drained -> out_valid=0 same cycle, count=0; new write after release appears at out_addr 0.
REQ-039 clr=1 with wr_en=1 and a transfer in same cycle -> count=0, overflow=0, nothing stored, out_valid=0 next cycle.
